audio_cic_integrator: RTL and testbench
=======================================

# audio_cic_integrator

Integrator-and-decimation front half of the CIC audio low-pass/decimator. It runs at the high input sample rate and accumulates the input through `STAGES` cascaded integrators. Every `RATE`-th input sample it emits one sample plus a one-clock strobe. It sits directly upstream of the comb stage (`audio_comb_filter`): `snd_out` drives the comb's `snd_in` and `cen_out` drives the comb's `cen`, with the comb instantiated at `IW = CALCW`.

## Interface
- `IW`, default 16: signed input sample width.
- `STAGES`, default 3: number of cascaded integrators; must be at least 1.
- `RATE`, default 4: decimation factor; must be at least 1.
- `DEPTH`, default 1: differential delay of the downstream comb; used only for bit growth.
- `CALCW` (localparam): `IW + STAGES*$clog2(RATE*DEPTH)`; width of all integrators and of `snd_out`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous reset, active-high.
- `cen_in`  in  1  input sample strobe; one sample is consumed per `clk` cycle in which it is high.
- `snd_in`  in  IW  signed input sample, valid while `cen_in` is high.
- `snd_out`  out  CALCW  signed decimated sample, two's complement.
- `cen_out`  out  1  one-`clk` strobe marking a new `snd_out`.

## Operation
- Sign-extend `snd_in` to `CALCW` bits (`ext`).
- Integrator registers `acc[0..STAGES-1]` are `CALCW` bits wide. On a `clk` edge with `cen_in` high:
  - `acc[0] <= acc[0] + ext`.
  - `acc[k] <= acc[k] + acc[k-1]` for k ≥ 1, using the pre-edge value of `acc[k-1]`. This makes the chain a registered pipeline.
- All additions are modulo 2^CALCW. Wrap-around is intentional and must not saturate, because the comb stage cancels it. There is no overflow flag.
- Phase counter `cnt`:
  - Width `$clog2(RATE)`, minimum 1 bit.
  - Increments on each `cen_in`.
  - When `cen_in` is high and `cnt == RATE-1`, `cnt` returns to 0. This is a decimation event.
- On a decimation event:
  - `snd_out` takes the post-edge value of `acc[STAGES-1]`, i.e. `acc[STAGES-1] + acc[STAGES-2]`, or `acc[0] + ext` when `STAGES == 1`.
  - `snd_out` holds until the next event.
- With `RATE == 1`, every `cen_in` is a decimation event.
- `cen_in` low: every register holds its value.
- `cen_in` may be high on consecutive cycles or arrive with arbitrary gaps.
- End-to-end gain with the comb stage is (RATE·DEPTH)^STAGES.

## Timing
- Reset: the following are all 0 on the edge after `reset` is high.
  - `acc[*] = 0`.
  - `cnt = 0`.
  - `snd_out = 0`.
  - `cen_out = 0`.
- Reset wins over a simultaneous `cen_in`. The sample arriving in that cycle is discarded.
- Reset mid-operation discards partial phase. The first output after reset follows the `RATE`-th `cen_in` after reset.
- `snd_out` updates on the decimation edge.
- `cen_out` is high for exactly the one `clk` cycle following the decimation edge, aligned with the new `snd_out`. It is never high for two consecutive cycles unless `RATE == 1` and `cen_in` is high continuously.
- Pipeline latency: input sample n first reaches `acc[k]` at input sample n+k, counted in `cen_in` events. The decimated output adds 1 `clk` of latency.

## Structure
- Package `audio_cic_pkg`:
  - Function `cic_calcw(iw, stages, rate, depth)`, shared by this block, the comb instances and the top wrapper.
  - Parameter-legality assertions for STAGES ≥ 1 and RATE ≥ 1.
- Sub-module `audio_cic_integ_stage`: one `CALCW`-wide accumulator with `clk`, `reset` and `cen`, instantiated `STAGES` times in a generate loop.
- Counter, output register and strobe logic live in the top module.

## Test plan
- Reset:
  - Drive `cen_in` = 1 and `snd_in` = 0x7FFF with `reset` held high.
  - `snd_out` = 0 and `cen_out` = 0 throughout.
  - After release, the first `cen_out` arrives after exactly 4 `cen_in` events (RATE = 4).
- DC ramp, STAGES=1, RATE=4, DEPTH=1 (CALCW = 18):
  - Hold `snd_in` = 1 with `cen_in` high continuously.
  - `cen_out` is high every 4th `clk`.
  - `snd_out` reads 4, 8, 12, 16.
- Impulse, STAGES=3, RATE=4, DEPTH=1 (CALCW = 22):
  - Drive `snd_in` = 1 for one sample, then 0.
  - Successive `snd_out` values are 3, 21, 55, which equal s(s−1)/2 at s = 3, 7, 11.
- Wrap-around, STAGES=1, RATE=2, DEPTH=1 (CALCW = 17):
  - Hold `snd_in` = −32768.
  - `snd_out` reads 0x10000 (−65536), then 0x00000.
  - No saturation occurs.
- Gapped strobe:
  - Repeat the DC-ramp case with `cen_in` high every 3rd `clk`.
  - `cen_out` is high every 12 `clk`.
  - Values are identical to the DC-ramp case.
  - Integrators are unchanged on idle cycles.
- Reset mid-operation:
  - Assert `reset` after 2 of 4 `cen_in` events, together with a `cen_in`.
  - All outputs clear.
  - The next `cen_out` follows exactly 4 post-reset `cen_in` events, with `snd_out` = 4 for DC input 1.

Source files
------------

// File: rtl/audio_cic_pkg.sv
// Shared CIC helpers: integrator width, phase-counter width and parameter legality.
package audio_cic_pkg;

    function automatic int cic_calcw(input int iw, input int stages, input int rate,
                                     input int depth);
        return iw + stages * $clog2(rate * depth);
    endfunction

    function automatic int cic_cntw(input int rate);
        return (rate > 1) ? $clog2(rate) : 1;
    endfunction

    function automatic bit cic_params_legal(input int stages, input int rate);
        return (stages >= 1) && (rate >= 1);
    endfunction

endpackage

// File: rtl/audio_cic_integ_stage.sv
// One wrapping CIC integrator: acc <= acc + add on each enabled clock.
module audio_cic_integ_stage #(
    parameter int unsigned W = 22
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cen,
    input  logic [W-1:0] add_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (cen) begin
            acc_d = acc_q + add_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/audio_cic_integrator.sv
// CIC integrator cascade plus decimator: emits one sample and a strobe every RATE input samples.
module audio_cic_integrator
    import audio_cic_pkg::*;
#(
    parameter int IW     = 16,
    parameter int STAGES = 3,
    parameter int RATE   = 4,
    parameter int DEPTH  = 1,
    localparam int CALCW = cic_calcw(IW, STAGES, RATE, DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cen_in,
    input  logic [IW-1:0]    snd_in,
    output logic [CALCW-1:0] snd_out,
    output logic             cen_out
);

    localparam int CntW = cic_cntw(RATE);
    localparam logic [CntW-1:0] CntMax = CntW'(RATE - 1);

    if (!cic_params_legal(STAGES, RATE)) begin : g_param_check
        $error("audio_cic_integrator: STAGES and RATE must both be at least 1");
    end

    logic [CALCW-1:0] ext;
    logic [STAGES-1:0][CALCW-1:0] acc;
    logic [STAGES-1:0][CALCW-1:0] add;
    logic [CALCW-1:0] last_sum;

    assign ext = CALCW'($signed(snd_in));

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign add[k] = ext;
        end else begin : g_rest
            assign add[k] = acc[k-1];
        end

        audio_cic_integ_stage #(
            .W(CALCW)
        ) u_stage (
            .clk  (clk),
            .reset(reset),
            .cen  (cen_in),
            .add_i(add[k]),
            .acc_o(acc[k])
        );
    end

    // Value the last integrator will hold after this edge.
    assign last_sum = acc[STAGES-1] + add[STAGES-1];

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CALCW-1:0] snd_q, snd_d;
    logic             cen_out_q, cen_out_d;
    logic             dec;

    always_comb begin
        dec       = cen_in && (cnt_q == CntMax);
        cnt_d     = cnt_q;
        snd_d     = snd_q;
        cen_out_d = dec;
        if (cen_in) begin
            cnt_d = dec ? '0 : cnt_q + 1'b1;
        end
        if (dec) begin
            snd_d = last_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            snd_q     <= '0;
            cen_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            snd_q     <= snd_d;
            cen_out_q <= cen_out_d;
        end
    end

    assign snd_out = snd_q;
    assign cen_out = cen_out_q;

endmodule

// File: tb/tb_audio_cic_integrator.sv
// Bench for audio_cic_integrator: three configurations against a closed-form binomial model.
module tb_audio_cic_integrator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cen_in;
    logic [15:0] snd_in;

    logic [21:0] snd_s3;
    logic        cen_s3;
    logic [17:0] snd_s1;
    logic        cen_s1;
    logic [16:0] snd_w;
    logic        cen_w;

    int n_assert = 0;
    int n_fail   = 0;
    int samples[$];

    always #5 clk = ~clk;

    audio_cic_integrator #(.IW(16), .STAGES(3), .RATE(4), .DEPTH(1)) u_s3 (
        .clk(clk), .reset(reset), .cen_in(cen_in), .snd_in(snd_in),
        .snd_out(snd_s3), .cen_out(cen_s3)
    );

    audio_cic_integrator #(.IW(16), .STAGES(1), .RATE(4), .DEPTH(1)) u_s1 (
        .clk(clk), .reset(reset), .cen_in(cen_in), .snd_in(snd_in),
        .snd_out(snd_s1), .cen_out(cen_s1)
    );

    audio_cic_integrator #(.IW(16), .STAGES(1), .RATE(2), .DEPTH(1)) u_w (
        .clk(clk), .reset(reset), .cen_in(cen_in), .snd_in(snd_in),
        .snd_out(snd_w), .cen_out(cen_w)
    );

    function automatic longint binom(input int n, input int k);
        longint r = 1;
        if (n < k) return 0;
        for (int j = 0; j < k; j++) r = r * longint'(n - j) / longint'(j + 1);
        return r;
    endfunction

    // Last integrator after m samples: sum of x[i] * C(m-1-i, STAGES-1).
    function automatic longint model(input int stages);
        longint s = 0;
        int m = samples.size();
        for (int i = 0; i < m; i++) s += longint'(samples[i]) * binom(m - 1 - i, stages - 1);
        return s;
    endfunction

    logic [21:0] e_s3;
    logic [17:0] e_s1;
    logic [16:0] e_w;
    logic        ec_s3, ec_s1, ec_w;

    task automatic chk(input string tag, input longint got, input longint exp_v);
        n_assert++;
        assert (got === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic [15:0] d);
        int m;
        reset  = r;
        cen_in = c;
        snd_in = d;
        @(posedge clk);
        if (r) begin
            samples.delete();
            e_s3 = '0; e_s1 = '0; e_w = '0;
            ec_s3 = 1'b0; ec_s1 = 1'b0; ec_w = 1'b0;
        end else if (c) begin
            samples.push_back(int'($signed(d)));
            m = samples.size();
            ec_s3 = (m % 4 == 0);
            ec_s1 = (m % 4 == 0);
            ec_w  = (m % 2 == 0);
            if (ec_s3) e_s3 = 22'(model(3));
            if (ec_s1) e_s1 = 18'(model(1));
            if (ec_w)  e_w  = 17'(model(1));
        end else begin
            ec_s3 = 1'b0; ec_s1 = 1'b0; ec_w = 1'b0;
        end
        #1;
        chk("s3_cen", longint'(cen_s3), longint'(ec_s3));
        chk("s3_snd", longint'(snd_s3), longint'(e_s3));
        chk("s1_cen", longint'(cen_s1), longint'(ec_s1));
        chk("s1_snd", longint'(snd_s1), longint'(e_s1));
        chk("w_cen",  longint'(cen_w),  longint'(ec_w));
        chk("w_snd",  longint'(snd_w),  longint'(e_w));
    endtask

    initial begin
        reset = 1'b1; cen_in = 1'b0; snd_in = '0;
        e_s3 = '0; e_s1 = '0; e_w = '0;
        ec_s3 = 1'b0; ec_s1 = 1'b0; ec_w = 1'b0;

        // Reset held with live strobe and full-scale input.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h7FFF);

        // DC ramp, continuous strobe.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0001);
        chk("dc_ramp_s1_16", longint'(snd_s1), 64'd16);

        // Gapped strobe: one sample every third clock.
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 48; i++) step(1'b0, (i % 3) == 0, 16'h0001);
        chk("gapped_s1_16", longint'(snd_s1), 64'd16);

        // Reset mid-phase together with a strobe.
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0001);
        step(1'b0, 1'b1, 16'h0001);
        step(1'b1, 1'b1, 16'h0001);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0001);
        chk("midreset_s1_4", longint'(snd_s1), 64'd4);

        // Impulse through three stages: 3, 21, 55.
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0001);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 16'h0000);
        chk("impulse_s3_55", longint'(snd_s3), 64'd55);

        // Wrap-around with full-scale negative input.
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h8000);
        step(1'b0, 1'b1, 16'h8000);
        chk("wrap_w_10000", longint'(snd_w), 64'h10000);
        step(1'b0, 1'b1, 16'h8000);
        step(1'b0, 1'b1, 16'h8000);
        chk("wrap_w_00000", longint'(snd_w), 64'h0);

        // Random samples, strobe pattern and occasional reset.
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
                 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
